// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the digit-serial adder/subtractor: the controller
// state width and the state encoding used by serial_adder.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int STATE_W = 2;

  // IDLE waits for start, RUN walks the digits, DONE is the one-cycle
  // completion state that carries the done pulse.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
// Purely combinational DIGIT-bit ripple-carry chain of full_adder cells.
// Ports:
//   a, b     : DIGIT-bit operand digits
//   cin      : carry into bit 0
//   s        : DIGIT-bit digit sum
//   cout     : carry out of the top bit
//   msb_cin  : carry into the top bit; XORed with cout by the caller to
//              form signed overflow on the final digit
// -----------------------------------------------------------------------------
module digit_adder
  import serial_adder_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             msb_cin
);

  // carry_s[i] is the carry into bit i; carry_s[DIGIT] leaves the chain.
  logic [DIGIT:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_chain
    full_adder u_fa (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (carry_s[gi]),
      .s    (s[gi]),
      .cout (carry_s[gi+1])
    );
  end

  assign cout    = carry_s[DIGIT];
  // For DIGIT=1 this is simply the incoming carry register value.
  assign msb_cin = carry_s[DIGIT-1];

endmodule : digit_adder

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Single-bit full adder, the cell the digit ripple chain is built from.
// Ports:
//   a, b  : addend bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Multi-cycle WIDTH-bit adder/subtractor processing DIGIT bits per clock,
// least significant digit first, with the carry held in a register between
// digits. Start/busy/done handshake; results only update on completion.
// Ports:
//   clk      : clock, all state changes on posedge
//   rst      : synchronous active-high reset, highest priority
//   start    : request, sampled only in IDLE
//   sub      : 0 = a+b+cin, 1 = a-b (cin ignored); captured with start
//   a, b     : WIDTH-bit operands, captured with start
//   cin      : carry in for add mode, captured with start
//   busy     : high while digits are being computed
//   done     : one-cycle pulse on the edge sum/cout/overflow update
//   sum      : last completed result (modulo 2^WIDTH)
//   cout     : final carry out; in sub mode 1 means no borrow (a >= b)
//   overflow : signed overflow of the last completed operation
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_adder: need WIDTH >= 2, 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  state_e             state_r;
  logic [WIDTH-1:0]   a_r;      // operand A, shifted right one digit per cycle
  logic [WIDTH-1:0]   b_r;      // operand B (already inverted for subtract)
  logic [WIDTH-1:0]   res_r;    // result digits enter from the MSB side
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [DIGIT-1:0]   dsum_s;
  logic               dcout_s;
  logic               dmsb_cin_s;
  logic [WIDTH+DIGIT-1:0] res_cat_s;
  logic [WIDTH-1:0]   res_next_s;
  logic               last_s;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a       (a_r[DIGIT-1:0]),
    .b       (b_r[DIGIT-1:0]),
    .cin     (carry_r),
    .s       (dsum_s),
    .cout    (dcout_s),
    .msb_cin (dmsb_cin_s)
  );

  // Shift the new digit in from the top; the concatenation keeps this legal
  // even when DIGIT == WIDTH (the whole result arrives in one cycle).
  assign res_cat_s  = {dsum_s, res_r};
  assign res_next_s = res_cat_s[WIDTH+DIGIT-1:DIGIT];
  assign last_s     = (cnt_r == CNT_W'(NDIG - 1));

  // Controller, operand/result shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      res_r    <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtract is a + ~b + 1: invert B once and seed the carry.
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          res_r   <= res_next_s;
          carry_r <= dcout_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_s) begin
            sum      <= res_next_s;
            cout     <= dcout_s;
            overflow <= dmsb_cin_s ^ dcout_s;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_r  <= DONE;
          end else begin
            done     <= 1'b0;
            busy     <= 1'b1;
            state_r  <= RUN;
          end
        end
        DONE: begin
          // start is deliberately not looked at here.
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Four serial_adder instances (WIDTH=8, DIGIT=1,2,4,8) share one stimulus
// stream; each is checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst, start, sub, cin;
  logic [7:0] a, b;

  logic [NI-1:0]      busy_v, done_v, cout_v, ovf_v;
  logic [NI-1:0][7:0] sum_v;

  int n_cmp = 0;
  int n_bad = 0;

  // Observation record filled by the record task.
  logic [NI-1:0] busy_h [0:15];
  int            done_t [NI];
  int            done_n [NI];
  logic [7:0]    got_sum [NI];
  logic          got_cout [NI];
  logic          got_ovf [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    serial_adder #(.WIDTH(8), .DIGIT(1 << gi)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy_v[gi]),
      .done     (done_v[gi]),
      .sum      (sum_v[gi]),
      .cout     (cout_v[gi]),
      .overflow (ovf_v[gi])
    );
  end

  // Reference: {ovf, cout, sum} from plain unsigned and signed arithmetic.
  function automatic logic [9:0] ref_model(input logic [7:0] ra, input logic [7:0] rb,
                                           input logic rsub, input logic rcin);
    int  ua, ub, us, sa, sb, ss;
    logic ov;
    ua = int'(ra);
    ub = int'(rb);
    sa = int'($signed(ra));
    sb = int'($signed(rb));
    if (rsub) begin
      us = ua + (255 - ub) + 1;
      ss = sa - sb;
    end else begin
      us = ua + ub + int'(rcin);
      ss = sa + sb + int'(rcin);
    end
    ov = (ss > 127) || (ss < -128);
    return {ov, us[8], us[7:0]};
  endfunction

  // Present an operation at the next falling edge with start high.
  task automatic launch(input logic [7:0] la, input logic [7:0] lb, input logic ls, input logic lc);
    @(negedge clk);
    a = la; b = lb; sub = ls; cin = lc; start = 1'b1;
    @(negedge clk);
  endtask

  // Sample n falling edges (t=0 is right after the start edge), scrambling
  // inputs every cycle; optionally re-assert start with a=inj_a at t=inj_t.
  task automatic record(input int n, input int inj_t, input logic [7:0] inj_a);
    for (int i = 0; i < NI; i++) begin
      done_t[i] = -1;
      done_n[i] = 0;
    end
    for (int t = 0; t < n; t++) begin
      if (t > 0) @(negedge clk);
      busy_h[t] = busy_v;
      for (int i = 0; i < NI; i++) begin
        if (done_v[i]) begin
          if (done_t[i] < 0) begin
            done_t[i]   = t;
            got_sum[i]  = sum_v[i];
            got_cout[i] = cout_v[i];
            got_ovf[i]  = ovf_v[i];
          end
          done_n[i]++;
        end
      end
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      if (t == inj_t) begin
        start = 1'b1;
        a = inj_a;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if ({busy_v[i], done_v[i], sum_v[i], cout_v[i], ovf_v[i]} !== 12'h000) begin
        n_bad++;
        $display("FAIL reset_state dig=%0d got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                 1 << i, busy_v[i], done_v[i], sum_v[i], cout_v[i], ovf_v[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] ta [7] = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'h10, 8'h00, 8'h80};
    logic [7:0] tb [7] = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h20, 8'h00, 8'h80};
    logic       ts [7] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
    logic       tc [7] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    logic [9:0] exp;
    logic       bok;
    int         nd;
    for (int j = 0; j < 7; j++) begin
      exp = ref_model(ta[j], tb[j], ts[j], tc[j]);
      launch(ta[j], tb[j], ts[j], tc[j]);
      record(10, -1, 8'h00);
      for (int i = 0; i < NI; i++) begin
        nd = 8 >> i;
        bok = 1'b1;
        for (int t = 0; t < nd; t++) if (!busy_h[t][i]) bok = 1'b0;
        if (busy_h[nd][i]) bok = 1'b0;
        n_cmp++;
        if (done_t[i] !== nd) begin
          n_bad++; $display("FAIL dir_latency dig=%0d op=%0d got=%0d want=%0d", 1 << i, j, done_t[i], nd);
        end
        n_cmp++;
        if (done_n[i] !== 1) begin
          n_bad++; $display("FAIL dir_done_count dig=%0d op=%0d got=%0d want=1", 1 << i, j, done_n[i]);
        end
        n_cmp++;
        if (bok !== 1'b1) begin
          n_bad++; $display("FAIL dir_busy dig=%0d op=%0d got=%b want=1", 1 << i, j, bok);
        end
        n_cmp++;
        if (got_sum[i] !== exp[7:0]) begin
          n_bad++; $display("FAIL dir_sum dig=%0d op=%0d got=%h want=%h", 1 << i, j, got_sum[i], exp[7:0]);
        end
        n_cmp++;
        if (got_cout[i] !== exp[8]) begin
          n_bad++; $display("FAIL dir_cout dig=%0d op=%0d got=%b want=%b", 1 << i, j, got_cout[i], exp[8]);
        end
        n_cmp++;
        if (got_ovf[i] !== exp[9]) begin
          n_bad++; $display("FAIL dir_ovf dig=%0d op=%0d got=%b want=%b", 1 << i, j, got_ovf[i], exp[9]);
        end
      end
    end
  endtask

  // Second start at t=2 must be ignored by every instance still in RUN or
  // DONE (DIGIT=1,2,4); the DIGIT=8 instance is already idle and excluded.
  task automatic test_busy_start();
    launch(8'h10, 8'h20, 1'b0, 1'b1);
    record(12, 2, 8'hAA);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (done_n[i] !== 1) begin
        n_bad++; $display("FAIL busy_done_count dig=%0d got=%0d want=1", 1 << i, done_n[i]);
      end
      n_cmp++;
      if (done_t[i] !== (8 >> i)) begin
        n_bad++; $display("FAIL busy_latency dig=%0d got=%0d want=%0d", 1 << i, done_t[i], 8 >> i);
      end
      n_cmp++;
      if ({got_ovf[i], got_cout[i], got_sum[i]} !== 10'h031) begin
        n_bad++; $display("FAIL busy_result dig=%0d got ovf=%b cout=%b sum=%h want 0 0 31",
                          1 << i, got_ovf[i], got_cout[i], got_sum[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int nd;
    launch(8'h3C, 8'h5A, 1'b0, 1'b0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if ({busy_v[i], done_v[i], sum_v[i], cout_v[i], ovf_v[i]} !== 12'h000) begin
        n_bad++;
        $display("FAIL midrun_reset dig=%0d got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                 1 << i, busy_v[i], done_v[i], sum_v[i], cout_v[i], ovf_v[i]);
      end
    end
    rst = 1'b0;
    nd = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      nd += $countones(done_v | busy_v);
    end
    n_cmp++;
    if (nd !== 0) begin
      n_bad++; $display("FAIL midrun_stale_activity got=%0d want=0", nd);
    end
    launch(8'h12, 8'h34, 1'b0, 1'b1);
    record(10, -1, 8'h00);
    n_cmp++;
    if (done_t[0] !== 8) begin
      n_bad++; $display("FAIL midrun_fresh_latency got=%0d want=8", done_t[0]);
    end
    n_cmp++;
    if ({got_ovf[0], got_cout[0], got_sum[0]} !== 10'h047) begin
      n_bad++; $display("FAIL midrun_fresh_result got ovf=%b cout=%b sum=%h want 0 0 47",
                        got_ovf[0], got_cout[0], got_sum[0]);
    end
  endtask

  task automatic test_random();
    logic [7:0] corner [4] = '{8'h00, 8'hFF, 8'h80, 8'h7F};
    logic [7:0] ra, rb;
    logic       rs, rc;
    logic [9:0] exp;
    for (int k = 0; k < 1000; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      exp = ref_model(ra, rb, rs, rc);
      launch(ra, rb, rs, rc);
      record(10, -1, 8'h00);
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if ((done_t[i] !== (8 >> i)) || (done_n[i] !== 1)) begin
          n_bad++; $display("FAIL rnd_timing dig=%0d got t=%0d n=%0d want t=%0d n=1",
                            1 << i, done_t[i], done_n[i], 8 >> i);
        end
        n_cmp++;
        if ({got_ovf[i], got_cout[i], got_sum[i]} !== exp) begin
          n_bad++; $display("FAIL rnd_result dig=%0d a=%h b=%h sub=%b cin=%b got=%b_%b_%h want=%b_%b_%h",
                            1 << i, ra, rb, rs, rc, got_ovf[i], got_cout[i], got_sum[i],
                            exp[9], exp[8], exp[7:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_start();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor, the sequential successor to the single-bit full_adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first, through a DIGIT-long ripple chain of full adders. The carry is held in a register between cycles.
- Uses a start/busy/done handshake. It is the team's building block for area-lean datapaths (ALU slices, accumulators) where latency can be traded for gates.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.
- DIGIT, 1, bits processed per cycle; 1 <= DIGIT <= WIDTH and WIDTH % DIGIT == 0 (elaboration error otherwise).
- NDIG, WIDTH/DIGIT (derived localparam), digit count, which equals the compute cycles.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b+cin, 1 = a-b (a + ~b + 1; cin ignored); captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in for add mode; captured with start.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse when the result registers update.
- sum  output  WIDTH  result; holds the last completed result.
- cout  output  1  final carry out; in sub mode 1 = no borrow (a >= b unsigned).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst high at posedge): state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, internal shift registers and carry cleared. Reset has priority over every other input, including mid-RUN; the in-flight operation is discarded and done is never raised for it.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k captures a, b (inverted if sub), carry = sub ? 1 : cin, digit counter = 0. State goes to RUN and busy=1 after edge k. With start=0 it stays in IDLE.
- RUN: each edge adds the lowest DIGIT bits of the operand registers plus carry through the ripple chain.
  - Result digit shifts into the result shift register from the MSB side; operand registers shift right by DIGIT.
  - Carry register takes the chain carry out; counter increments.
  - On the edge where counter == NDIG-1 (edge k+NDIG), sum, cout and overflow load together from the final values.
  - Also on that edge: done=1, busy=0, state goes to DONE.
- DONE: lasts exactly one cycle; next edge returns to IDLE and done=0. start is ignored in DONE.
- start is ignored while busy (RUN); the operation completes with the originally captured operands, and input changes during RUN have no effect.
- Latency: start edge to done-high is NDIG cycles. Back-to-back throughput is one operation per NDIG+2 cycles.
- sum, cout and overflow never show partial results. They change only on the completion edge or on reset.
- Overflow source: the carry into the MSB is the chain-internal carry at bit DIGIT-1 of the last digit. For DIGIT=1 it is the carry register value entering the last cycle.
- Arithmetic is modulo 2^WIDTH. Wrap-around is reported only through cout and overflow.
- DIGIT==WIDTH is legal: single-cycle compute, done one edge after start.

Decomposition:
- Shared package serial_adder_pkg: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the state width.
- Sub-module: digit_adder, a purely combinational DIGIT-bit ripple chain instantiating the existing full_adder DIGIT times via generate. Its outputs are the digit sum, carry out and MSB carry-in (used for overflow).
- The FSM, counter and shift registers live in serial_adder.

Test Plan:
- WIDTH=8, DIGIT=1: a=8'hFF, b=8'h01, cin=0, sub=0, start pulse -> done exactly 8 cycles later; sum=8'h00, cout=1, overflow=0; busy high for those 8 cycles.
- WIDTH=8, DIGIT=4: a=8'h7F, b=8'h01, cin=0 -> done after 2 cycles; sum=8'h80, cout=0, overflow=1.
- WIDTH=8, DIGIT=2, sub=1: a=8'h05, b=8'h07 -> sum=8'hFE, cout=0, overflow=0. Then a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, overflow=1.
- Start while busy, plus operand changes mid-RUN (first a=8'h10, b=8'h20, cin=1; second start a=8'hAA at cycle 3) -> single done with sum=8'h31; second start ignored, no extra done.
- Reset mid-RUN at cycle 4 of 8 -> next cycle busy=0, done=0, sum=0, cout=0, overflow=0, state IDLE; a fresh start completes normally in 8 cycles.
- Randomised self-check over 1000 operations for (DIGIT=1, 2, 4, 8) against the reference expression {cout,sum} = a + (sub ? ~b : b) + (sub ? 1 : cin); overflow is checked against signed comparison.
